// File: rtl/b2a_rand_gen.sv
// Random-word source for B2A unmasking: RANDNUM independent xorshift32 lanes, registered outputs, one-cycle seed-to-valid latency.
// Backpressure: lanes advance only on i_en while valid; after RESEED_INTERVAL draws o_rvld drops until a new seed arrives.
module b2a_rand_gen #(
    parameter int K_WIDTH         = 32,
    parameter int RANDNUM         = 2,
    parameter int RESEED_INTERVAL = 1024,
    parameter int CNT_W           = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       i_seed_vld,
    input  logic [K_WIDTH*RANDNUM-1:0] i_seed,
    input  logic                       i_en,
    output logic [K_WIDTH*RANDNUM-1:0] o_n,
    output logic                       o_rvld,
    output logic                       o_expired,
    output logic [CNT_W-1:0]           o_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam bit               EXPIRE_EN = (RESEED_INTERVAL != 0);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(RESEED_INTERVAL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t                     state_q, state_d;
    logic [K_WIDTH*RANDNUM-1:0] lane_q, lane_d;
    logic [K_WIDTH*RANDNUM-1:0] seed_fix, lane_step;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       draw;
    logic                       last_draw;

    // Taps are fixed for a 32-bit word; K_WIDTH other than 32 is unsupported.
    function automatic logic [K_WIDTH-1:0] xorshift32(input logic [K_WIDTH-1:0] x);
        logic [K_WIDTH-1:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // Each lane only ever sees its own seed slice and its own state.
    for (genvar g = 0; g < RANDNUM; g++) begin : g_lane
        assign seed_fix[g*K_WIDTH +: K_WIDTH] =
            (i_seed[g*K_WIDTH +: K_WIDTH] == '0) ? K_WIDTH'(g + 1)
                                                 : i_seed[g*K_WIDTH +: K_WIDTH];
        assign lane_step[g*K_WIDTH +: K_WIDTH] = xorshift32(lane_q[g*K_WIDTH +: K_WIDTH]);
    end

    // A seed strobe always wins over a simultaneous draw request.
    assign draw      = (state_q == RUN) && i_en && !i_seed_vld;
    assign last_draw = draw && EXPIRE_EN && (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        if (i_seed_vld) begin
            lane_d  = seed_fix;
            cnt_d   = '0;
            state_d = RUN;
        end else if (draw) begin
            lane_d = lane_step;
            if (!EXPIRE_EN) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
            if (last_draw) begin
                state_d = EXPIRED;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q <= '0;
            cnt_q  <= '0;
        end else begin
            lane_q <= lane_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_n       = lane_q;
    assign o_rvld    = (state_q == RUN);
    assign o_expired = (state_q == EXPIRED);
    assign o_cnt     = cnt_q;

endmodule

// File: tb/tb_b2a_rand_gen.sv
// Scoreboard bench for b2a_rand_gen with a short reseed interval so expiry is reachable.
module tb_b2a_rand_gen;

    localparam int RI = 4;

    logic        clk;
    logic        rst_ni;
    logic        i_seed_vld;
    logic [63:0] i_seed;
    logic        i_en;
    logic [63:0] o_n;
    logic        o_rvld;
    logic        o_expired;
    logic [15:0] o_cnt;

    typedef struct packed {
        logic [63:0] n;
        logic        rvld;
        logic        expd;
        logic [15:0] cnt;
    } obs_t;

    obs_t sb[$];

    logic [31:0] m_lane [2];
    logic [15:0] m_cnt;
    int          m_state;  // 0 idle, 1 run, 2 expired

    int n_checks;
    int n_fail;

    b2a_rand_gen #(
        .K_WIDTH(32),
        .RANDNUM(2),
        .RESEED_INTERVAL(RI),
        .CNT_W(16)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .i_seed_vld(i_seed_vld),
        .i_seed(i_seed),
        .i_en(i_en),
        .o_n(o_n),
        .o_rvld(o_rvld),
        .o_expired(o_expired),
        .o_cnt(o_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] xs(input logic [31:0] v);
        logic [31:0] x;
        x = v;
        x ^= x << 13;
        x ^= x >> 17;
        x ^= x << 5;
        return x;
    endfunction

    function automatic obs_t sample();
        obs_t s;
        s.n    = o_n;
        s.rvld = o_rvld;
        s.expd = o_expired;
        s.cnt  = o_cnt;
        return s;
    endfunction

    function automatic string fmt(input obs_t s);
        return $sformatf("n=%h rvld=%b exp=%b cnt=%0d", s.n, s.rvld, s.expd, s.cnt);
    endfunction

    task automatic model_reset();
        m_lane[0] = '0;
        m_lane[1] = '0;
        m_cnt     = '0;
        m_state   = 0;
        sb.delete();
    endtask

    // Drives one cycle of stimulus, pushes the expected post-edge outputs, and steps past the edge.
    task automatic drive(input logic sv, input logic [63:0] sd, input logic en);
        obs_t e;
        i_seed_vld = sv;
        i_seed     = sd;
        i_en       = en;
        if (sv) begin
            for (int i = 0; i < 2; i++) begin
                m_lane[i] = (sd[i*32 +: 32] == 32'd0) ? 32'(i + 1) : sd[i*32 +: 32];
            end
            m_cnt   = '0;
            m_state = 1;
        end else if (en && m_state == 1) begin
            for (int i = 0; i < 2; i++) m_lane[i] = xs(m_lane[i]);
            m_cnt = m_cnt + 16'd1;
            if (m_cnt == 16'(RI)) m_state = 2;
        end
        e.n    = {m_lane[1], m_lane[0]};
        e.rvld = (m_state == 1);
        e.expd = (m_state == 2);
        e.cnt  = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        i_seed_vld = 1'b0;
        i_en       = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        rst_ni     = 1'b0;
        i_seed_vld = 1'b0;
        i_seed     = '0;
        i_en       = 1'b0;
        model_reset();
        #2;
        got = sample();
        n_checks++;
        if (got !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL reset_state: got %s, expected all zero", fmt(got));
        end
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 64'd0, 1'b1);
            got = sample();
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp || got.n !== 64'd0) begin
                n_fail++;
                $display("FAIL idle_en[%0d]: got %s, expected %s", k, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_seed_one();
        obs_t got, exp;
        drive(1'b1, {32'd1, 32'd1}, 1'b0);
        got = sample();
        exp = sb.pop_front();
        n_checks++;
        if (got !== exp || o_n !== {32'h1, 32'h1} || o_rvld !== 1'b1) begin
            n_fail++;
            $display("FAIL seed_one_load: got %s, expected %s", fmt(got), fmt(exp));
        end
        drive(1'b0, 64'd0, 1'b1);
        got = sample();
        exp = sb.pop_front();
        n_checks++;
        if (got !== exp || o_n !== {32'h00042021, 32'h00042021} || o_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL seed_one_draw: got %s, expected %s", fmt(got), fmt(exp));
        end
    endtask

    task automatic test_zero_seed();
        obs_t got, exp;
        drive(1'b1, 64'd0, 1'b0);
        got = sample();
        exp = sb.pop_front();
        n_checks++;
        if (got !== exp || o_n !== {32'h2, 32'h1}) begin
            n_fail++;
            $display("FAIL zero_seed_load: got %s, expected %s", fmt(got), fmt(exp));
        end
        drive(1'b0, 64'd0, 1'b1);
        got = sample();
        exp = sb.pop_front();
        n_checks++;
        if (got !== exp || o_n[31:0] !== 32'h00042021) begin
            n_fail++;
            $display("FAIL zero_seed_draw: got %s, expected %s", fmt(got), fmt(exp));
        end
    endtask

    task automatic test_expiry();
        obs_t        got, exp;
        logic [31:0] a, b;
        a = 32'hDEADBEEF;
        b = 32'h12345678;
        drive(1'b1, {b, a}, 1'b0);
        void'(sb.pop_front());
        for (int k = 0; k < RI; k++) begin
            a = xs(a);
            b = xs(b);
        end
        for (int k = 0; k < RI + 4; k++) begin
            drive(1'b0, 64'd0, 1'b1);
            got = sample();
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL expiry_step[%0d]: got %s, expected %s", k, fmt(got), fmt(exp));
            end
        end
        n_checks++;
        if (o_n !== {b, a} || o_cnt !== 16'(RI) || o_expired !== 1'b1 || o_rvld !== 1'b0) begin
            n_fail++;
            $display("FAIL expiry_hold: got %s, expected n=%h rvld=0 exp=1 cnt=%0d",
                     fmt(sample()), {b, a}, RI);
        end
        drive(1'b1, 64'h0000_0055_0000_00AA, 1'b0);
        got = sample();
        exp = sb.pop_front();
        n_checks++;
        if (got !== exp || o_cnt !== 16'd0 || o_rvld !== 1'b1 || o_expired !== 1'b0) begin
            n_fail++;
            $display("FAIL expiry_reseed: got %s, expected %s", fmt(got), fmt(exp));
        end
    endtask

    task automatic test_seed_priority();
        obs_t got, exp;
        drive(1'b1, 64'h1111_2222_3333_4444, 1'b0);
        void'(sb.pop_front());
        drive(1'b0, 64'd0, 1'b1);
        void'(sb.pop_front());
        drive(1'b0, 64'd0, 1'b1);
        void'(sb.pop_front());
        drive(1'b1, 64'hCAFE_F00D_0BAD_BEEF, 1'b1);
        got = sample();
        exp = sb.pop_front();
        n_checks++;
        if (got !== exp || o_n !== 64'hCAFE_F00D_0BAD_BEEF || o_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL seed_priority: got %s, expected %s", fmt(got), fmt(exp));
        end
    endtask

    task automatic test_back_to_back();
        obs_t        got, exp;
        logic        sv, en;
        logic [63:0] sd;
        for (int k = 0; k < 150; k++) begin
            sv = ($urandom_range(0, 11) == 0);
            en = ($urandom_range(0, 3) != 0);
            sd = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) sd[31:0] = 32'd0;
            if ($urandom_range(0, 3) == 0) sd[63:32] = 32'd0;
            drive(sv, sd, en);
            got = sample();
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random[%0d]: got %s, expected %s", k, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t got, exp;
        drive(1'b1, 64'h0F0F_0F0F_A5A5_A5A5, 1'b0);
        void'(sb.pop_front());
        drive(1'b0, 64'd0, 1'b1);
        void'(sb.pop_front());
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        got = sample();
        n_checks++;
        if (got !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL async_reset: got %s, expected all zero", fmt(got));
        end
        #2;
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 64'd0, 1'b1);
            got = sample();
            exp = sb.pop_front();
            n_checks++;
            if (got !== exp || o_rvld !== 1'b0 || o_n !== 64'd0) begin
                n_fail++;
                $display("FAIL post_reset_idle[%0d]: got %s, expected %s", k, fmt(got), fmt(exp));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_seed_one();
        test_zero_seed();
        test_expiry();
        test_seed_priority();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
